// File: rtl/pwm_driver_if.sv
// Sample bus from the waveform combiner into the PWM output stage.
// The combiner drives a one-cycle ready strobe alongside each combined sample.
interface pwm_driver_if #(
  parameter int WIDTH = 9
) ();
  logic             ready;
  logic [WIDTH-1:0] sample;

  modport master (output ready, output sample);
  modport slave  (input  ready, input  sample);
endinterface

// File: rtl/pwm_driver.sv
// Audio PWM output stage: double-buffers combiner samples and emits a
// period-aligned, flop-driven PWM bit with period-start and sticky debug flags.
module pwm_driver #(
  parameter int WIDTH  = 9,
  parameter int PERIOD = 511
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        en,
  pwm_driver_if.slave smp,
  input  logic        clr_flags,
  output logic        pwm_out,
  output logic        period_start,
  output logic        underrun,
  output logic        overrun
);

  localparam logic [WIDTH-1:0] PERIOD_W = WIDTH'(PERIOD);
  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(PERIOD - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] counter_reg, counter_next;
  logic [WIDTH-1:0] duty_reg, duty_next;
  logic [WIDTH-1:0] pending_reg, pending_next;
  logic             pend_valid_reg, pend_valid_next;
  logic             underrun_next, overrun_next;
  logic             pwm_next, period_start_next;
  logic             boundary, consume, underrun_set, overrun_set;
  logic             wrap;
  logic [WIDTH-1:0] sample_sat;

  // Oversized samples clamp to full scale instead of wrapping.
  assign sample_sat = (smp.sample > PERIOD_W) ? PERIOD_W : smp.sample;
  assign wrap       = (counter_reg == LAST_CNT);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg      <= IDLE;
      counter_reg    <= '0;
      duty_reg       <= '0;
      pending_reg    <= '0;
      pend_valid_reg <= 1'b0;
      pwm_out        <= 1'b0;
      period_start   <= 1'b0;
      underrun       <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      counter_reg    <= counter_next;
      duty_reg       <= duty_next;
      pending_reg    <= pending_next;
      pend_valid_reg <= pend_valid_next;
      pwm_out        <= pwm_next;
      period_start   <= period_start_next;
      underrun       <= underrun_next;
      overrun        <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    boundary     = 1'b0;
    underrun_set = 1'b0;

    case (state_reg)
      IDLE: begin
        counter_next = '0;
        if (en) begin
          state_next = RUN;
          boundary   = 1'b1;
        end
      end
      RUN: begin
        if (wrap) begin
          counter_next = '0;
          if (en) begin
            boundary     = 1'b1;
            underrun_set = ~pend_valid_reg;
          end else begin
            state_next = DRAIN;
          end
        end else begin
          counter_next = counter_reg + WIDTH'(1);
        end
      end
      DRAIN: begin
        counter_next = '0;
        state_next   = IDLE;
      end
      default: begin
        counter_next = '0;
        state_next   = IDLE;
      end
    endcase

    // A boundary consumes the pending sample; a same-cycle strobe refills it.
    consume         = boundary & pend_valid_reg;
    duty_next       = consume ? pending_reg : duty_reg;
    pending_next    = smp.ready ? sample_sat : pending_reg;
    pend_valid_next = smp.ready | (pend_valid_reg & ~consume);
    overrun_set     = smp.ready & pend_valid_reg & ~consume;

    underrun_next = underrun_set | (underrun & ~clr_flags);
    overrun_next  = overrun_set  | (overrun  & ~clr_flags);

    // Outputs are computed from next-state values so the flops align with the counter.
    pwm_next          = (state_next == RUN) && (counter_next < duty_next);
    period_start_next = (state_next == RUN) && (counter_next == '0);
  end

endmodule

// File: tb/tb_pwm_driver.sv
// Bench for pwm_driver: two instances (PERIOD 511 and 300) share one stimulus
// stream; a period-level reference model feeds a scoreboard read by a monitor.
module tb_pwm_driver;
  localparam int WIDTH = 9;
  localparam int P0    = 511;
  localparam int P1    = 300;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       en;
  logic       clr_flags;
  logic [1:0] pwm_out, period_start, underrun, overrun;

  pwm_driver_if #(.WIDTH(WIDTH)) smp_bus ();

  always #5 clk = ~clk;

  pwm_driver #(.WIDTH(WIDTH), .PERIOD(P0)) dut0 (
    .clk(clk), .n_rst(n_rst), .en(en), .smp(smp_bus.slave), .clr_flags(clr_flags),
    .pwm_out(pwm_out[0]), .period_start(period_start[0]),
    .underrun(underrun[0]), .overrun(overrun[0])
  );

  pwm_driver #(.WIDTH(WIDTH), .PERIOD(P1)) dut1 (
    .clk(clk), .n_rst(n_rst), .en(en), .smp(smp_bus.slave), .clr_flags(clr_flags),
    .pwm_out(pwm_out[1]), .period_start(period_start[1]),
    .underrun(underrun[1]), .overrun(overrun[1])
  );

  // Reference: "where are we in the current period" plus the sample buffer.
  typedef struct {
    bit run;
    bit drain;
    int pos;
    int duty;
    bit has_pend;
    int pend;
    bit ur;
    bit ov;
  } model_t;

  typedef struct {
    int         cyc;
    logic [1:0] pwm;
    logic [1:0] ps;
    logic [1:0] ur;
    logic [1:0] ov;
  } exp_t;

  model_t mdl [2];
  exp_t   exp_q [$];
  exp_t   mon_x;
  int     cyc    = 0;
  int     checks = 0;
  int     errors = 0;
  int     hi_cnt = 0;
  int     per_n  = 0;
  bit     in_per = 0;
  bit     en_r;
  int     rs;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d got %b want %b", name, cyc, act, req);
    end
  endtask

  task automatic model_reset(input int i);
    mdl[i] = '{run: 0, drain: 0, pos: 0, duty: 0, has_pend: 0, pend: 0, ur: 0, ov: 0};
  endtask

  // Advances model i across the next clock edge using the inputs now applied.
  task automatic model_step(input int i, input int p);
    bit last, boundary, consume, ur_set, ov_set;
    int s;
    if (!n_rst) begin
      model_reset(i);
      return;
    end
    last     = mdl[i].run && (mdl[i].pos == p - 1);
    boundary = en && ((!mdl[i].run && !mdl[i].drain) || last);
    consume  = boundary && mdl[i].has_pend;
    ur_set   = last && en && !mdl[i].has_pend;
    ov_set   = smp_bus.ready && mdl[i].has_pend && !consume;
    if (consume) mdl[i].duty = mdl[i].pend;
    mdl[i].has_pend = smp_bus.ready || (mdl[i].has_pend && !consume);
    if (smp_bus.ready) begin
      s = int'(smp_bus.sample);
      mdl[i].pend = (s > p) ? p : s;
    end
    mdl[i].ur = ur_set || (mdl[i].ur && !clr_flags);
    mdl[i].ov = ov_set || (mdl[i].ov && !clr_flags);
    if (mdl[i].run) begin
      if (!last) mdl[i].pos++;
      else if (en) mdl[i].pos = 0;
      else begin
        mdl[i].run   = 0;
        mdl[i].drain = 1;
      end
    end else if (mdl[i].drain) begin
      mdl[i].drain = 0;
    end else if (en) begin
      mdl[i].run = 1;
      mdl[i].pos = 0;
    end
  endtask

  // Applies one cycle of stimulus, queues the predicted outputs, returns 1ns after the edge.
  task automatic drive(input bit e, input bit r, input int s, input bit c);
    exp_t x;
    en            = e;
    smp_bus.ready = r;
    smp_bus.sample = WIDTH'(s);
    clr_flags     = c;
    model_step(0, P0);
    model_step(1, P1);
    x.cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      x.pwm[i] = mdl[i].run && (mdl[i].pos < mdl[i].duty);
      x.ps[i]  = mdl[i].run && (mdl[i].pos == 0);
      x.ur[i]  = mdl[i].ur;
      x.ov[i]  = mdl[i].ov;
    end
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_pos(input int target, input bit e);
    int n = 0;
    while (!(mdl[0].run && mdl[0].pos == target) && n < 2000) begin
      drive(e, 0, 0, 0);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL run_until_pos target %0d not reached got pos %0d", target, mdl[0].pos);
    end
  endtask

  // Monitor: compares DUT outputs against the queued prediction for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_x = exp_q.pop_front();
        check("pwm_out", pwm_out, mon_x.pwm);
        check("period_start", period_start, mon_x.ps);
        check("underrun", underrun, mon_x.ur);
        check("overrun", overrun, mon_x.ov);
      end
      if (period_start[0]) begin
        if (in_per) $display("period %0d high_cycles %0d", per_n, hi_cnt);
        per_n++;
        in_per = 1;
        hi_cnt = 0;
      end
      if (pwm_out[0]) hi_cnt++;
    end
  end

  initial begin
    n_rst = 1'b0; en = 1'b0; clr_flags = 1'b0;
    smp_bus.ready = 1'b0; smp_bus.sample = '0;
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    #1;
    check("reset_pwm", pwm_out, 2'b00);
    check("reset_ps", period_start, 2'b00);
    check("reset_flags", {underrun[0], overrun[0]}, 2'b00);
    repeat (3) drive(0, 0, 0, 0);
    n_rst = 1'b1;

    // One sample of 100 before the first period, then three periods with no refill.
    drive(0, 1, 100, 0);
    drive(1, 0, 0, 0);
    check("first_period_start", period_start[0], 1'b1);
    repeat (3 * P0) drive(1, 0, 0, 0);
    check("underrun_no_refill", underrun[0], 1'b1);
    drive(1, 0, 0, 1);

    // Full-scale and zero samples.
    drive(1, 1, 0, 0);
    repeat (2 * P0) drive(1, 0, 0, 0);
    drive(1, 1, 511, 0);
    repeat (2 * P0) drive(1, 0, 0, 0);

    // Two strobes in one period: overrun, newest sample wins, then clear.
    run_until_pos(5, 1);
    drive(1, 1, 10, 0);
    repeat (20) drive(1, 0, 0, 0);
    drive(1, 1, 20, 0);
    check("overrun_set", overrun[0], 1'b1);
    run_until_pos(10, 1);
    drive(1, 0, 0, 1);
    check("overrun_clr", overrun[0], 1'b0);

    // Strobe on the exact wrap cycle while 30 is pending.
    run_until_pos(20, 1);
    drive(1, 1, 30, 0);
    run_until_pos(P0 - 1, 1);
    drive(1, 1, 50, 0);
    run_until_pos(P0 - 1, 1);
    drive(1, 1, 300, 0);
    check("wrap_flags", {underrun[0], overrun[0]}, 2'b00);

    // en dropped at counter 200 with duty 300.
    run_until_pos(P0 - 1, 1);
    drive(1, 0, 0, 0);
    run_until_pos(200, 1);
    repeat (400) drive(0, 0, 0, 0);
    check("idle_after_drop", {pwm_out[0], period_start[0]}, 2'b00);

    // en back on during DRAIN: new period two cycles later.
    drive(1, 0, 0, 0);
    run_until_pos(P0 - 1, 1);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    check("drain_restart_wait", period_start[0], 1'b0);
    drive(1, 0, 0, 0);
    check("drain_restart", period_start[0], 1'b1);

    // Asynchronous reset while pwm_out is high.
    drive(1, 1, 400, 0);
    run_until_pos(P0 - 1, 1);
    drive(1, 0, 0, 0);
    run_until_pos(50, 1);
    check("pre_reset_high", pwm_out[0], 1'b1);
    #2;
    n_rst = 1'b0;
    exp_q.delete();
    model_reset(0);
    model_reset(1);
    #1;
    check("async_rst_pwm", pwm_out, 2'b00);
    check("async_rst_ps", period_start, 2'b00);
    check("async_rst_flags", {underrun, overrun}, 4'b0000);
    @(posedge clk);
    #1;
    repeat (2) drive(1, 0, 0, 0);
    n_rst = 1'b1;
    repeat (P0 + 10) drive(1, 0, 0, 0);

    // Randomized traffic with boundary-biased samples.
    en_r = 1'b1;
    for (int k = 0; k < 30000; k++) begin
      if ($urandom_range(0, 699) == 0) en_r = ~en_r;
      case ($urandom_range(0, 6))
        0: rs = 0;
        1: rs = P1;
        2: rs = P1 + 1;
        3: rs = P0;
        4: rs = P0 - 1;
        default: rs = $urandom_range(0, 511);
      endcase
      drive(en_r, ($urandom_range(0, 149) == 0), rs, ($urandom_range(0, 499) == 0));
    end
    drive(0, 0, 0, 0);
    #10;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_driver.md
Name: pwm_driver

Overview:
- Audio output stage directly downstream of the waveform combiner.
- Captures each 9-bit combined sample on the combiner's ready strobe and double-buffers it.
- Converts the sample into a glitch-free, period-aligned PWM bit for the speaker pin.
- Reports status: period-start pulse, plus sticky underrun and overrun flags for debug.

Parameters:
- WIDTH, 9, sample and counter width in bits.
- PERIOD, 511, PWM period in clock cycles. Counter runs 0..PERIOD-1. Requires PERIOD <= 2^WIDTH - 1.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  reset, asynchronous, active-low.
- en  input  1  run enable from the top-level control.
- ready  input  1  one-cycle strobe; sample is valid this cycle.
- sample  input  WIDTH  combined waveform value, unsigned.
- clr_flags  input  1  synchronous clear of the underrun and overrun flags.
- pwm_out  output  1  PWM bit, registered.
- period_start  output  1  one-cycle pulse on the first cycle of each PWM period.
- underrun  output  1  sticky: a period boundary found no new sample.
- overrun  output  1  sticky: a pending sample was overwritten before use.

Behaviour:
- Reset (n_rst=0, any time, asynchronous):
  - state=IDLE, counter=0, duty=0, pending=0, pend_valid=0.
  - pwm_out=0, period_start=0, underrun=0, overrun=0.
- Capture (active in every state):
  - ready=1 loads pending<=min(sample, PERIOD) and sets pend_valid=1.
  - If pend_valid was already 1 and is not being consumed this cycle, set overrun.
- State machine, 3 states:
  - IDLE: counter=0, pwm_out=0. When en=1, go to RUN next cycle.
  - RUN: counter increments each cycle and wraps PERIOD-1 -> 0.
    - On wrap with en=0, go to DRAIN.
  - DRAIN: one cycle with pwm_out=0, then IDLE. Captured pending survives for the next RUN.
- Period boundary (entry to RUN from IDLE, or counter wrap with en=1):
  - duty <= pending if pend_valid=1, and pend_valid clears.
  - Otherwise duty keeps its previous value and underrun is set. Underrun is not set on the entry from IDLE.
  - If ready=1 in the same cycle, the new sample goes to pending for the following period. Set wins over clear on pend_valid. Overrun is not flagged in this case.
- Output timing:
  - period_start=1 on the cycle counter=0 in RUN; 0 otherwise.
  - For a period whose first cycle is T: pwm_out=1 on cycles T..T+duty-1 and 0 on T+duty..T+PERIOD-1.
  - duty=0 gives constant low. duty=PERIOD gives constant high.
  - pwm_out comes straight from a flop, so it never glitches.
- en deasserted mid-period: the current period completes unchanged and no truncated pulse is produced.
- en reasserted while in DRAIN: the block still passes through IDLE; a new period starts 2 cycles later.
- clr_flags=1 clears both flags. A same-cycle set event wins over the clear.
- Width rules:
  - Comparisons are unsigned WIDTH bits.
  - Samples above PERIOD saturate to PERIOD; they are never wrapped.

Test Plan:
- Reset, then en=1 with one ready and sample=100 before the first period:
  - Next period_start followed by exactly 100 cycles pwm_out=1 and 411 cycles pwm_out=0.
  - period_start pulses every 511 cycles.
  - Expect underrun=1 after the second boundary, since no new sample arrived.
- Boundaries: sample=0 gives constant pwm_out=0. sample=511 gives constant 1 for the full period. sample=511 with PERIOD=300 saturates to constant 1.
- Two ready strobes (sample=10, then sample=20) inside one period:
  - overrun=1.
  - Next period uses duty=20.
  - clr_flags then returns overrun to 0.
- ready with sample=50 on the exact wrap cycle while pending=30:
  - Next period uses duty=30, the one after uses duty=50.
  - No overrun or underrun raised.
- en dropped at counter=200 with duty=300:
  - pwm_out stays high through cycle 299, the period completes, then DRAIN and IDLE.
  - pwm_out=0 and period_start never pulses again until en=1.
- n_rst asserted mid-period with pwm_out=1:
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release with en=1, the first period starts from counter=0 with duty=0.
